// File: rtl/note_hit_judge.sv
// Per-lane hit/miss judge: turns note arrivals and raw buttons into hit/miss
// pulses, a saturating combo, max combo and saturating hit/miss totals.
module note_hit_judge #(
  parameter int unsigned WINDOW = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [1:0]       note_arrive,
  input  logic [1:0]       btn,
  output logic [1:0]       hit,
  output logic [1:0]       miss,
  output logic [7:0]       combo,
  output logic [7:0]       max_combo,
  output logic [CNT_W-1:0] hit_total,
  output logic [CNT_W-1:0] miss_total
);

  localparam int unsigned LANES   = 2;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned COMBO_W = 8;
  localparam int unsigned SUM_W   = COMBO_W + 1;
  localparam int unsigned TOT_W   = CNT_W + 1;
  localparam logic [TIMER_W-1:0] WIN_LOAD = TIMER_W'(WINDOW);

  logic [LANES-1:0] s1_q, s2_q, s3_q;
  logic [LANES-1:0] rise_c;
  logic [LANES-1:0][TIMER_W-1:0] timer_q, timer_d;
  logic [LANES-1:0] hit_q, hit_d, miss_q, miss_d;
  logic [COMBO_W-1:0] combo_q, combo_d, max_combo_q, max_combo_d;
  logic [CNT_W-1:0] hit_total_q, hit_total_d, miss_total_q, miss_total_d;
  logic [1:0] hit_cnt_c, miss_cnt_c;
  logic [SUM_W-1:0] combo_sum_c;
  logic [TOT_W-1:0] hit_sum_c, miss_sum_c;

  assign rise_c = s2_q & ~s3_q;

  // Window timers: priority order matters when several events coincide.
  always_comb begin
    timer_d = timer_q;
    hit_d   = '0;
    miss_d  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (!active) begin
        timer_d[i] = '0;
      end else if ((timer_q[i] != '0) && rise_c[i]) begin
        hit_d[i]   = 1'b1;
        timer_d[i] = note_arrive[i] ? WIN_LOAD : '0;
      end else if ((timer_q[i] != '0) && note_arrive[i]) begin
        miss_d[i]  = 1'b1;
        timer_d[i] = WIN_LOAD;
      end else if (timer_q[i] == TIMER_W'(1)) begin
        miss_d[i]  = 1'b1;
        timer_d[i] = '0;
      end else if ((timer_q[i] == '0) && note_arrive[i]) begin
        timer_d[i] = WIN_LOAD;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TIMER_W'(1);
      end
    end
  end

  // Combo and totals follow the pulses being registered on this edge.
  always_comb begin
    hit_cnt_c   = 2'({1'b0, hit_d[0]}) + 2'({1'b0, hit_d[1]});
    miss_cnt_c  = 2'({1'b0, miss_d[0]}) + 2'({1'b0, miss_d[1]});
    combo_sum_c = {1'b0, combo_q} + SUM_W'(hit_cnt_c);
    hit_sum_c   = {1'b0, hit_total_q} + TOT_W'(hit_cnt_c);
    miss_sum_c  = {1'b0, miss_total_q} + TOT_W'(miss_cnt_c);

    if (miss_d != '0) begin
      combo_d = COMBO_W'(hit_cnt_c);
    end else if (combo_sum_c[SUM_W-1]) begin
      combo_d = '1;
    end else begin
      combo_d = combo_sum_c[COMBO_W-1:0];
    end
    max_combo_d  = (combo_d > max_combo_q) ? combo_d : max_combo_q;
    hit_total_d  = hit_sum_c[TOT_W-1]  ? '1 : hit_sum_c[CNT_W-1:0];
    miss_total_d = miss_sum_c[TOT_W-1] ? '1 : miss_sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      timer_q      <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      combo_q      <= '0;
      max_combo_q  <= '0;
      hit_total_q  <= '0;
      miss_total_q <= '0;
    end else begin
      s1_q         <= btn;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      timer_q      <= timer_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      combo_q      <= combo_d;
      max_combo_q  <= max_combo_d;
      hit_total_q  <= hit_total_d;
      miss_total_q <= miss_total_d;
    end
  end

  assign hit        = hit_q;
  assign miss       = miss_q;
  assign combo      = combo_q;
  assign max_combo  = max_combo_q;
  assign hit_total  = hit_total_q;
  assign miss_total = miss_total_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// Randomized bench for note_hit_judge: a deadline-based reference model fills a
// scoreboard queue at each edge; a negedge monitor pops and compares.
module tb_note_hit_judge;

  localparam int unsigned WINDOW = 24;
  localparam int unsigned CNT_W  = 16;
  localparam int          TOT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [1:0]       hit;
    logic [1:0]       miss;
    logic [7:0]       combo;
    logic [7:0]       maxc;
    logic [CNT_W-1:0] ht;
    logic [CNT_W-1:0] mt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             active = 1'b0;
  logic [1:0]       note_arrive = '0;
  logic [1:0]       btn = '0;
  logic [1:0]       hit, miss;
  logic [7:0]       combo, max_combo;
  logic [CNT_W-1:0] hit_total, miss_total;

  note_hit_judge #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .active(active), .note_arrive(note_arrive),
    .btn(btn), .hit(hit), .miss(miss), .combo(combo), .max_combo(max_combo),
    .hit_total(hit_total), .miss_total(miss_total)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model: each open note is an absolute deadline edge number.
  int   n_edge = 0;
  int   dl[2];
  int   m_combo, m_max, m_ht, m_mt;
  logic [1:0] b1, b2, b3;  // btn sampled 1, 2 and 3 edges ago

  task automatic model_clear();
    dl[0] = 0; dl[1] = 0;
    m_combo = 0; m_max = 0; m_ht = 0; m_mt = 0;
    b1 = '0; b2 = '0; b3 = '0;
  endtask

  task automatic model_edge();
    exp_t e;
    logic [1:0] r, h, m;
    int hc, mc;
    n_edge++;
    h = '0; m = '0;
    if (reset) begin
      model_clear();
    end else begin
      r = b2 & ~b3;
      for (int l = 0; l < 2; l++) begin
        if (!active) dl[l] = 0;
        else if (dl[l] >= n_edge && r[l]) begin
          h[l] = 1'b1;
          dl[l] = note_arrive[l] ? n_edge + int'(WINDOW) : 0;
        end else if (dl[l] >= n_edge && note_arrive[l]) begin
          m[l] = 1'b1;
          dl[l] = n_edge + int'(WINDOW);
        end else if (dl[l] == n_edge) begin
          m[l] = 1'b1;
          dl[l] = 0;
        end else if (dl[l] < n_edge && note_arrive[l]) begin
          dl[l] = n_edge + int'(WINDOW);
        end
      end
      hc = int'(h[0]) + int'(h[1]);
      mc = int'(m[0]) + int'(m[1]);
      if (mc != 0) m_combo = hc;
      else m_combo = (m_combo + hc > 255) ? 255 : m_combo + hc;
      if (m_combo > m_max) m_max = m_combo;
      m_ht = (m_ht + hc > TOT_MAX) ? TOT_MAX : m_ht + hc;
      m_mt = (m_mt + mc > TOT_MAX) ? TOT_MAX : m_mt + mc;
      b3 = b2; b2 = b1; b1 = btn;
    end
    e.hit = h; e.miss = m;
    e.combo = 8'(m_combo); e.maxc = 8'(m_max);
    e.ht = CNT_W'(m_ht); e.mt = CNT_W'(m_mt);
    sbq.push_back(e);
  endtask

  // One clock: model the edge just taken, then drive the next cycle's inputs.
  task automatic step(input logic a, input logic [1:0] na, input logic [1:0] b,
                      input logic r);
    exp_t z;
    @(posedge clk);
    model_edge();
    #1;
    active = a; note_arrive = na; btn = b;
    if (r && !reset) begin
      z = '{hit: '0, miss: '0, combo: '0, maxc: '0, ht: '0, mt: '0};
      if (sbq.size() > 0) sbq[sbq.size()-1] = z;
      model_clear();
    end
    reset = r;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("hit", 32'(hit), 32'(e.hit));
      chk("miss", 32'(miss), 32'(e.miss));
      chk("combo", 32'(combo), 32'(e.combo));
      chk("max_combo", 32'(max_combo), 32'(e.maxc));
      chk("hit_total", 32'(hit_total), 32'(e.ht));
      chk("miss_total", 32'(miss_total), 32'(e.mt));
    end
  end

  logic [1:0] bcur;
  logic [1:0] na;
  int pa, pb;

  initial begin
    model_clear();
    bcur = '0;
    repeat (3) step(1'b0, 2'b00, 2'b00, 1'b1);
    step(1'b1, 2'b00, 2'b00, 1'b0);

    // Random phases with varying arrival and button activity.
    for (int p = 0; p < 6; p++) begin
      pa = 2 + p * 3;
      pb = 5 + p * 6;
      for (int c = 0; c < 350; c++) begin
        na = '0;
        for (int l = 0; l < 2; l++) begin
          if ($urandom_range(0, 99) < pa) na[l] = 1'b1;
          if ($urandom_range(0, 99) < pb) bcur[l] = ~bcur[l];
        end
        step((p == 3) ? ($urandom_range(0, 99) >= 10) : 1'b1, na, bcur, 1'b0);
      end
    end

    // Held button across two arrivals on lane 1, then windows close.
    bcur = '0;
    step(1'b1, 2'b10, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b10, 1'b0);
    repeat (6) step(1'b1, 2'b00, 2'b10, 1'b0);
    step(1'b1, 2'b10, 2'b10, 1'b0);
    repeat (30) step(1'b1, 2'b00, 2'b10, 1'b0);
    repeat (4) step(1'b1, 2'b00, 2'b00, 1'b0);

    // Active dropped mid-window: no miss, combo held.
    step(1'b1, 2'b11, 2'b00, 1'b0);
    repeat (5) step(1'b1, 2'b00, 2'b00, 1'b0);
    repeat (40) step(1'b0, 2'b00, 2'b00, 1'b0);

    // Reset mid-window: outputs clear at once, no miss afterwards.
    step(1'b1, 2'b01, 2'b00, 1'b0);
    repeat (5) step(1'b1, 2'b00, 2'b00, 1'b0);
    step(1'b1, 2'b00, 2'b00, 1'b1);
    step(1'b1, 2'b00, 2'b00, 1'b1);
    repeat (40) step(1'b1, 2'b00, 2'b00, 1'b0);

    // Long lane-0 hit streak drives combo into saturation.
    for (int k = 0; k < 262; k++) begin
      step(1'b1, 2'b01, 2'b00, 1'b0);
      step(1'b1, 2'b00, 2'b01, 1'b0);
      step(1'b1, 2'b00, 2'b01, 1'b0);
      step(1'b1, 2'b00, 2'b00, 1'b0);
      step(1'b1, 2'b00, 2'b00, 1'b0);
    end
    // Expiry after saturation drops combo to 0, max stays.
    step(1'b1, 2'b10, 2'b00, 1'b0);
    repeat (30) step(1'b1, 2'b00, 2'b00, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
